muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU. It owns the shared 32-bit ALU for the duration of an operation and drives its operand/control inputs every cycle. Multiply uses shift-add and divide uses restoring division, with sign pre- and post-correction also done through the ALU. Results land in the HI/LO registers. The block sits beside the execute stage, and the pipeline stalls on `busy`.

## Interface
Parameters:
- `XLEN`, 32, datapath width; fixed at 32.
- `ITERS`, 32, iteration count; equals `XLEN`.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  launch request; sampled only in IDLE or DONE.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs_val`  in  32  multiplicand / dividend.
- `rt_val`  in  32  multiplier / divisor.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse; `hi`/`lo` are valid.
- `hi`  out  32  HI register (product high / remainder).
- `lo`  out  32  LO register (product low / quotient).
- `alu_op1`  out  32  ALU operand1.
- `alu_op2`  out  32  ALU operand2.
- `alu_ctrl`  out  4  ALU control code.
- `alu_result`  in  32  ALU result.
- `alu_zero`  in  1  ALU zero flag.

## Operation
- States: IDLE, NEG_A, NEG_B, ITER, FIX1, FIX2, FIX3, DONE.
- IDLE/DONE with `start`=1:
  - latch `op`, `rs_val`, `rt_val`;
  - record sign flags `sa`, `sb` (signed ops only, else 0);
  - record `dz` = divide op and `rt_val`==0;
  - go to NEG_A.
- Idle ALU drive: ADD (0010) with operands 0.
- NEG_A: if `sa`, ALU SUB (0110) computes 0-a, else ADD a+0; result becomes magnitude A. NEG_B does the same for B.
- ITER: runs exactly 32 cycles, counted by a 5-bit counter that wraps 31→0 and exits.
- Multiply init: `hi`=0, `lo`=|B|, `mcand`=|A|. Each cycle:
  - ALU ADD `hi` + (`lo[0]` ? `mcand` : 0);
  - carry = (`alu_result` < `hi`), unsigned;
  - {`hi`,`lo`} ← {carry, `alu_result`, `lo`[31:1]}.
- Divide init: `hi`=0, `lo`=|A|, divisor=|B|. Each cycle:
  - `rs` = {`hi`[30:0], `lo`[31]}, `msb` = `hi`[31];
  - ALU SUB `rs` − divisor;
  - `take` = `msb` | (`rs` ≥ divisor);
  - `hi` ← `take` ? `alu_result` : `rs`;
  - `lo` ← {`lo`[30:0], `take`}.
- Multiply sign fix, applied when `sa`^`sb`:
  - FIX1: ALU SUB 0−`lo` → `lo`; latch `lz` = `alu_zero` of the pre-negation `lo` test.
  - FIX2: ALU NOR (1100) `hi`,0 → `hi`.
  - FIX3: ALU ADD `hi` + `lz` → `hi`.
- Divide sign fix:
  - FIX1: negate `lo` if `sa`^`sb`.
  - FIX2: negate `hi` if `sa`.
  - FIX3: idle pass-through.
- When no fix applies, the FIX states issue ADD x+0 (pass-through). Latency is always fixed.
- `dz`=1: FIX states pass through. Final result is `hi`=raw `rs_val`, `lo`=32'hFFFFFFFF.
- DONE: `done`=1; next state is IDLE, or NEG_A if `start`=1.
- `start` while `busy` is ignored.
- 0x80000000 negates to itself and is treated as unsigned magnitude 2^31, which is correct.

## Timing
- Reset values: state IDLE; `busy`, `done`, `hi`, `lo`, `alu_op1`, `alu_op2` = 0; `alu_ctrl` = 0010.
- `rst_n` low mid-operation aborts immediately to the reset state. No `done` is issued.
- `start` sampled at edge 0 gives:
  - NEG_A in cycle 1, NEG_B in cycle 2;
  - ITER in cycles 3–34;
  - FIX1–FIX3 in cycles 35–37;
  - DONE in cycle 38.
- `busy`=1 in cycles 1–37 and 0 in DONE.
- `hi`/`lo` hold their final values from cycle 38 until the next operation reaches ITER.
- ALU outputs are combinational from state and registers. `alu_result` is consumed in the same cycle, so the ALU path is one cycle.

## Structure
- Shared package `muldiv_pkg` holds:
  - `op` encodings;
  - ALU control constants ADD 4'b0010, SUB 4'b0110, NOR 4'b1100;
  - the state enum.
- The ALU control constants must match the ALU module's encodings.
- No sub-module: one FSM plus an inline datapath (hi, lo, operand, counter, flags).

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001; `done` exactly 38 cycles after `start`.
- MULT −3 × 5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. MULT 0x80000000 × 0x80000000 → `hi`=0x40000000, `lo`=0.
- DIV −7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 100 / 7 → `lo`=14, `hi`=2.
- DIVU 100 / 0 and DIV −5 / 0 → `hi`=rs_val raw, `lo`=0xFFFFFFFF, same 38-cycle latency.
- `start` pulsed at cycles 5 and 20 of an operation → ignored, result unchanged. `start` held in DONE → back-to-back op with `busy` rising next cycle.
- `rst_n` asserted in cycle 10 of an operation → all outputs reach reset values asynchronously, no `done`. Next op after release is correct.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide sequencer: operation codes, ALU control
// codes (must track the ALU's own decode) and the sequencer state enum.
package muldiv_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   typedef enum logic [2:0] {
      S_IDLE,
      S_NEG_A,
      S_NEG_B,
      S_ITER,
      S_FIX1,
      S_FIX2,
      S_FIX3,
      S_DONE
   } state_e;

   function automatic logic is_div(input logic [1:0] op);
      return op[1];
   endfunction

   function automatic logic is_signed_op(input logic [1:0] op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that borrows the shared execute-stage ALU:
// shift-add multiply, restoring divide, sign correction done through the same ALU.
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int ITERS = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] rs_val,
   input  logic [XLEN-1:0] rt_val,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo,
   output logic [XLEN-1:0] alu_op1,
   output logic [XLEN-1:0] alu_op2,
   output logic [3:0]      alu_ctrl,
   input  logic [XLEN-1:0] alu_result,
   input  logic            alu_zero
);

   localparam int CW = $clog2(ITERS);

   state_e          state_q, state_d;
   logic [1:0]      op_q, op_d;
   logic [XLEN-1:0] a_q, a_d;
   logic [XLEN-1:0] b_q, b_d;
   logic [XLEN-1:0] opnd_q, opnd_d;
   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            sa_q, sa_d;
   logic            sb_q, sb_d;
   logic            dz_q, dz_d;
   logic            lz_q, lz_d;

   logic            div_op;
   logic            mul_fix;
   logic            neg_lo;
   logic [XLEN-1:0] rs;
   logic            take;
   logic            carry;

   assign div_op  = is_div(op_q);
   assign mul_fix = !div_op && (sa_q ^ sb_q);
   // Divide-by-zero results are forced at the end, so no sign fix may touch them.
   assign neg_lo  = !dz_q && (sa_q ^ sb_q);

   assign busy = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done = (state_q == S_DONE);
   assign hi   = hi_q;
   assign lo   = lo_q;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      opnd_d   = opnd_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      cnt_d    = cnt_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      dz_d     = dz_q;
      lz_d     = lz_q;
      alu_op1  = '0;
      alu_op2  = '0;
      alu_ctrl = ALU_ADD;
      rs       = '0;
      take     = 1'b0;
      carry    = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
               op_d    = op;
               a_d     = rs_val;
               b_d     = rt_val;
               sa_d    = is_signed_op(op) && rs_val[XLEN-1];
               sb_d    = is_signed_op(op) && rt_val[XLEN-1];
               dz_d    = is_div(op) && (rt_val == '0);
               state_d = S_NEG_A;
            end
         end
         S_NEG_A: begin
            if (sa_q) begin
               alu_op2  = a_q;
               alu_ctrl = ALU_SUB;
            end else begin
               alu_op1  = a_q;
            end
            opnd_d  = alu_result;
            state_d = S_NEG_B;
         end
         S_NEG_B: begin
            if (sb_q) begin
               alu_op2  = b_q;
               alu_ctrl = ALU_SUB;
            end else begin
               alu_op1  = b_q;
            end
            hi_d  = '0;
            cnt_d = '0;
            // Multiply keeps |A| as multiplicand; divide moves |A| into LO and keeps |B|.
            if (div_op) begin
               lo_d   = opnd_q;
               opnd_d = alu_result;
            end else begin
               lo_d   = alu_result;
            end
            state_d = S_ITER;
         end
         S_ITER: begin
            if (div_op) begin
               rs       = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
               alu_op1  = rs;
               alu_op2  = opnd_q;
               alu_ctrl = ALU_SUB;
               take     = hi_q[XLEN-1] || (rs >= opnd_q);
               hi_d     = take ? alu_result : rs;
               lo_d     = {lo_q[XLEN-2:0], take};
            end else begin
               alu_op1  = hi_q;
               alu_op2  = lo_q[0] ? opnd_q : '0;
               carry    = (alu_result < hi_q);
               hi_d     = {carry, alu_result[XLEN-1:1]};
               lo_d     = {alu_result[0], lo_q[XLEN-1:1]};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(ITERS - 1)) begin
               state_d = S_FIX1;
            end
         end
         S_FIX1: begin
            if (neg_lo) begin
               alu_op2  = lo_q;
               alu_ctrl = ALU_SUB;
            end else begin
               alu_op1  = lo_q;
            end
            lo_d    = alu_result;
            lz_d    = alu_zero;
            state_d = S_FIX2;
         end
         S_FIX2: begin
            alu_op1 = hi_q;
            if (mul_fix) begin
               alu_ctrl = ALU_NOR;
            end else if (div_op && sa_q && !dz_q) begin
               alu_op1  = '0;
               alu_op2  = hi_q;
               alu_ctrl = ALU_SUB;
            end
            hi_d    = alu_result;
            state_d = S_FIX3;
         end
         S_FIX3: begin
            alu_op1 = hi_q;
            // Completes the 64-bit negate: the borrow into HI exists only when LO was zero.
            if (mul_fix) begin
               alu_op2 = {{(XLEN-1){1'b0}}, lz_q};
            end
            hi_d = alu_result;
            if (dz_q) begin
               hi_d = a_q;
               lo_d = '1;
            end
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         opnd_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         cnt_q   <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         dz_q    <= 1'b0;
         lz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         opnd_q  <= opnd_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         cnt_q   <= cnt_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         dz_q    <= dz_d;
         lz_q    <= lz_d;
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: models the shared ALU, runs a vector table of
// hand-computed results, then the start-ignore, back-to-back and reset-abort sequences.
module tb_muldiv_seq;
   import muldiv_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] alu_op1;
   logic [31:0] alu_op2;
   logic [3:0]  alu_ctrl;
   logic [31:0] alu_result;
   logic        alu_zero;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   vec_t vecs[15];

   muldiv_seq #(.XLEN(32), .ITERS(32)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .op(op),
      .rs_val(rs_val),
      .rt_val(rt_val),
      .busy(busy),
      .done(done),
      .hi(hi),
      .lo(lo),
      .alu_op1(alu_op1),
      .alu_op2(alu_op2),
      .alu_ctrl(alu_ctrl),
      .alu_result(alu_result),
      .alu_zero(alu_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model of the execute-stage ALU the sequencer borrows.
   always_comb begin
      alu_result = '0;
      case (alu_ctrl)
         4'b0010: alu_result = alu_op1 + alu_op2;
         4'b0110: alu_result = alu_op1 - alu_op2;
         4'b1100: alu_result = ~(alu_op1 | alu_op2);
         default: alu_result = '0;
      endcase
      alu_zero = (alu_result == '0);
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Launches one operation and waits for done; optional start pulses land mid-flight.
   task automatic applyStimulus(input logic [1:0] v_op, input logic [31:0] v_rs,
                                input logic [31:0] v_rt, input int pulse1, input int pulse2,
                                output int lat);
      op     = v_op;
      rs_val = v_rs;
      rt_val = v_rt;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat   = 1;
      while (!done && lat < 100) begin
         if (lat == pulse1 || lat == pulse2) begin
            start  = 1'b1;
            op     = OP_MULTU;
            rs_val = 32'hDEADBEEF;
            rt_val = 32'h00000003;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         lat++;
      end
      start = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lat;
      int abort_done;

      vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
      vecs[2]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[3]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[4]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
      vecs[5]  = '{OP_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
      vecs[6]  = '{OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
      vecs[7]  = '{OP_MULT,  32'd7,        32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6};
      vecs[8]  = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
      vecs[9]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
      vecs[10] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
      vecs[11] = '{OP_MULT,  32'd0,        32'hFFFFFFFB, 32'd0,        32'd0};
      vecs[12] = '{OP_MULT,  32'h00010000, 32'hFFFF0000, 32'hFFFFFFFF, 32'h00000000};
      vecs[13] = '{OP_DIVU,  32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 32'h00000001};
      vecs[14] = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};

      rst_n  = 1'b0;
      start  = 1'b0;
      op     = '0;
      rs_val = '0;
      rt_val = '0;
      #12;
      checkOutput("reset_busy", {31'b0, busy}, 32'd0);
      checkOutput("reset_done", {31'b0, done}, 32'd0);
      checkOutput("reset_hi", hi, 32'd0);
      checkOutput("reset_lo", lo, 32'd0);
      checkOutput("reset_alu_ctrl", {28'b0, alu_ctrl}, 32'h2);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i].op, vecs[i].rs, vecs[i].rt, 0, 0, lat);
         checkOutput($sformatf("v%0d_latency", i), lat, 32'd38);
         checkOutput($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
         checkOutput($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
         checkOutput($sformatf("v%0d_busy_in_done", i), {31'b0, busy}, 32'd0);
         @(posedge clk);
         #1;
         checkOutput($sformatf("v%0d_done_pulse", i), {31'b0, done}, 32'd0);
         checkOutput($sformatf("v%0d_hi_hold", i), hi, vecs[i].exp_hi);
      end

      $display("[TB] start pulses while busy");
      applyStimulus(OP_DIVU, 32'd100, 32'd7, 5, 20, lat);
      checkOutput("ignore_latency", lat, 32'd38);
      checkOutput("ignore_hi", hi, 32'd2);
      checkOutput("ignore_lo", lo, 32'd14);

      $display("[TB] back-to-back via start held in DONE");
      applyStimulus(OP_MULTU, 32'd6, 32'd7, 0, 0, lat);
      checkOutput("b2b_first_lo", lo, 32'd42);
      op     = OP_DIV;
      rs_val = 32'hFFFFFF9C;
      rt_val = 32'd7;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("b2b_busy_next", {31'b0, busy}, 32'd1);
      checkOutput("b2b_done_low", {31'b0, done}, 32'd0);
      lat = 1;
      while (!done && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checkOutput("b2b_latency", lat, 32'd38);
      checkOutput("b2b_hi", hi, 32'hFFFFFFFE);
      checkOutput("b2b_lo", lo, 32'hFFFFFFF2);
      @(posedge clk);
      #1;

      $display("[TB] reset abort mid-operation");
      op     = OP_DIVU;
      rs_val = 32'd1000;
      rt_val = 32'd3;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int c = 1; c < 10; c++) begin
         @(posedge clk);
         #1;
      end
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("abort_busy", {31'b0, busy}, 32'd0);
      checkOutput("abort_done", {31'b0, done}, 32'd0);
      checkOutput("abort_hi", hi, 32'd0);
      checkOutput("abort_lo", lo, 32'd0);
      checkOutput("abort_op1", alu_op1, 32'd0);
      checkOutput("abort_op2", alu_op2, 32'd0);
      checkOutput("abort_ctrl", {28'b0, alu_ctrl}, 32'h2);
      abort_done = 0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         if (done) abort_done++;
      end
      rst_n = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (done) abort_done++;
      end
      checkOutput("abort_no_done", abort_done, 32'd0);
      applyStimulus(OP_MULT, 32'hFFFFFFF9, 32'd6, 0, 0, lat);
      checkOutput("after_abort_latency", lat, 32'd38);
      checkOutput("after_abort_hi", hi, 32'hFFFFFFFF);
      checkOutput("after_abort_lo", lo, 32'hFFFFFFD6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
